// File: rtl/ysyx_24080014_arb_pkg.sv
// Shared encodings and the round-robin pick used by the data-memory arbiter.
// Both encodings are one bit wide.
package ysyx_24080014_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

    // A tie goes to whichever requester did not win the previous grant.
    function automatic arb_owner_e rr_pick(input logic ifu_req,
                                           input logic lsu_req,
                                           input arb_owner_e last_gnt);
        arb_owner_e pick;
        if (ifu_req && lsu_req) begin
            pick = (last_gnt == OWN_LSU) ? OWN_IFU : OWN_LSU;
        end else if (lsu_req) begin
            pick = OWN_LSU;
        end else begin
            pick = OWN_IFU;
        end
        return pick;
    endfunction

endpackage

// File: rtl/ysyx_24080014_mem_arbiter.sv
// Shares the data-memory port between IFU (read-only) and LSU (read/write).
// One transaction in flight at a time; a watchdog aborts a memory that never answers.
module ysyx_24080014_mem_arbiter
    import ysyx_24080014_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_gnt,
    output logic        ifu_resp,
    output logic [31:0] ifu_rdata,
    output logic        ifu_err,
    input  logic        lsu_req,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_gnt,
    output logic        lsu_resp,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_valid,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e       state_r;
    arb_state_e       state_nxt_s;
    arb_owner_e       owner_r;
    arb_owner_e       last_gnt_r;
    arb_owner_e       grant_owner_s;
    logic             grant_s;
    logic             done_ok_s;
    logic             done_to_s;
    logic             busy_s;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      addr_r;
    logic [31:0]      wdata_r;
    logic [7:0]       wmask_r;
    logic             ren_r;
    logic             wen_r;
    logic             ifu_resp_r;
    logic             lsu_resp_r;
    logic [31:0]      ifu_rdata_r;
    logic [31:0]      lsu_rdata_r;
    logic             ifu_err_r;
    logic             lsu_err_r;

    // Next-state, grant and completion decode.
    always_comb begin
        state_nxt_s   = state_r;
        grant_s       = 1'b0;
        grant_owner_s = OWN_IFU;
        done_ok_s     = 1'b0;
        done_to_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Grants are suppressed while reset is held so every output reads 0.
                if (rst && (ifu_req || lsu_req)) begin
                    grant_s       = 1'b1;
                    grant_owner_s = rr_pick(ifu_req, lsu_req, last_gnt_r);
                    state_nxt_s   = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    done_ok_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    done_to_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, ownership history and watchdog counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            owner_r    <= OWN_IFU;
            last_gnt_r <= OWN_LSU;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (grant_s) begin
                owner_r    <= grant_owner_s;
                last_gnt_r <= grant_owner_s;
                cnt_r      <= {CNT_W{1'b0}};
            end else if (state_r == ST_BUSY) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Request capture; the memory sees only these registers while busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            wmask_r <= 8'h00;
            ren_r   <= 1'b0;
            wen_r   <= 1'b0;
        end else if (grant_s) begin
            if (grant_owner_s == OWN_LSU) begin
                addr_r  <= lsu_addr;
                wdata_r <= lsu_wdata;
                wmask_r <= lsu_wmask;
                ren_r   <= !lsu_wen;
                wen_r   <= lsu_wen;
            end else begin
                addr_r  <= ifu_addr;
                wdata_r <= 32'h0000_0000;
                wmask_r <= 8'h00;
                ren_r   <= 1'b1;
                wen_r   <= 1'b0;
            end
        end
    end

    // Response pulse plus per-requester data/error that hold until the next response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifu_resp_r  <= 1'b0;
            lsu_resp_r  <= 1'b0;
            ifu_rdata_r <= 32'h0000_0000;
            lsu_rdata_r <= 32'h0000_0000;
            ifu_err_r   <= 1'b0;
            lsu_err_r   <= 1'b0;
        end else begin
            ifu_resp_r <= 1'b0;
            lsu_resp_r <= 1'b0;
            if (done_ok_s || done_to_s) begin
                if (owner_r == OWN_LSU) begin
                    lsu_resp_r  <= 1'b1;
                    lsu_err_r   <= done_to_s;
                    lsu_rdata_r <= (done_ok_s && !wen_r) ? mem_rdata : 32'h0000_0000;
                end else begin
                    ifu_resp_r  <= 1'b1;
                    ifu_err_r   <= done_to_s;
                    ifu_rdata_r <= done_ok_s ? mem_rdata : 32'h0000_0000;
                end
            end
        end
    end

    assign busy_s    = (state_r == ST_BUSY);
    assign ifu_gnt   = grant_s && (grant_owner_s == OWN_IFU);
    assign lsu_gnt   = grant_s && (grant_owner_s == OWN_LSU);
    assign ifu_resp  = ifu_resp_r;
    assign lsu_resp  = lsu_resp_r;
    assign ifu_rdata = ifu_rdata_r;
    assign lsu_rdata = lsu_rdata_r;
    assign ifu_err   = ifu_err_r;
    assign lsu_err   = lsu_err_r;
    assign mem_valid = busy_s;
    assign mem_ren   = busy_s && ren_r;
    assign mem_wen   = busy_s && wen_r;
    assign mem_raddr = addr_r;
    assign mem_waddr = addr_r;
    assign mem_wdata = wdata_r;
    assign mem_wmask = wmask_r;

endmodule

// File: tb/tb_ysyx_24080014_mem_arbiter.sv
// Directed plus randomized bench for the memory arbiter against a transaction-level model.
// Inputs change on the falling edge; outputs are sampled 1 ns after it.
module tb_ysyx_24080014_mem_arbiter;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_gnt;
    logic        ifu_resp;
    logic [31:0] ifu_rdata;
    logic        ifu_err;
    logic        lsu_req;
    logic        lsu_wen;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_gnt;
    logic        lsu_resp;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        mem_valid;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_cmp = 0;
    int n_err = 0;

    // Model: who won the last grant, and what each requester should currently show.
    bit          last_lsu;
    logic [31:0] exp_ifu_rdata;
    logic [31:0] exp_lsu_rdata;
    logic        exp_ifu_err;
    logic        exp_lsu_err;

    ysyx_24080014_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ifu_req   (ifu_req),
        .ifu_addr  (ifu_addr),
        .ifu_gnt   (ifu_gnt),
        .ifu_resp  (ifu_resp),
        .ifu_rdata (ifu_rdata),
        .ifu_err   (ifu_err),
        .lsu_req   (lsu_req),
        .lsu_wen   (lsu_wen),
        .lsu_addr  (lsu_addr),
        .lsu_wdata (lsu_wdata),
        .lsu_wmask (lsu_wmask),
        .lsu_gnt   (lsu_gnt),
        .lsu_resp  (lsu_resp),
        .lsu_rdata (lsu_rdata),
        .lsu_err   (lsu_err),
        .mem_valid (mem_valid),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_raddr (mem_raddr),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish within 500000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        last_lsu      = 1'b1;
        exp_ifu_rdata = 32'h0;
        exp_lsu_rdata = 32'h0;
        exp_ifu_err   = 1'b0;
        exp_lsu_err   = 1'b0;
    endtask

    task automatic reset_check();
        chk1("rst_mem_valid", mem_valid, 1'b0);
        chk1("rst_mem_ren", mem_ren, 1'b0);
        chk1("rst_mem_wen", mem_wen, 1'b0);
        chk32("rst_mem_raddr", mem_raddr, 32'h0);
        chk32("rst_mem_waddr", mem_waddr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk32("rst_mem_wmask", {24'h0, mem_wmask}, 32'h0);
        chk1("rst_ifu_gnt", ifu_gnt, 1'b0);
        chk1("rst_lsu_gnt", lsu_gnt, 1'b0);
        chk1("rst_ifu_resp", ifu_resp, 1'b0);
        chk1("rst_lsu_resp", lsu_resp, 1'b0);
        chk32("rst_ifu_rdata", ifu_rdata, 32'h0);
        chk32("rst_lsu_rdata", lsu_rdata, 32'h0);
        chk1("rst_ifu_err", ifu_err, 1'b0);
        chk1("rst_lsu_err", lsu_err, 1'b0);
    endtask

    // Idle cycles with mem_ready noise, which must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ifu_req   = 1'b0;
            lsu_req   = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            #1;
            chk1("idle_mem_valid", mem_valid, 1'b0);
            chk1("idle_ifu_resp", ifu_resp, 1'b0);
            chk1("idle_lsu_resp", lsu_resp, 1'b0);
        end
        mem_ready = 1'b0;
    endtask

    // One transaction starting in the current (idle) cycle. lat = cycle of mem_ready
    // after the grant; lat > TMO means the memory never answers.
    task automatic txn(input bit ir, input bit lr, input bit lw,
                       input logic [31:0] ia, input logic [31:0] la,
                       input logic [31:0] wd, input logic [7:0] wm,
                       input int lat, input logic [31:0] rd);
        bit          win_lsu;
        bit          ok;
        int          busy_cycles;
        logic [31:0] ea;
        ifu_req   = ir;
        lsu_req   = lr;
        ifu_addr  = ia;
        lsu_addr  = la;
        lsu_wen   = lw;
        lsu_wdata = wd;
        lsu_wmask = wm;
        mem_ready = 1'b0;
        win_lsu     = (ir && lr) ? !last_lsu : lr;
        ok          = (lat <= TMO);
        busy_cycles = ok ? lat : TMO;
        ea          = win_lsu ? la : ia;
        #1;
        chk1("ifu_gnt", ifu_gnt, !win_lsu);
        chk1("lsu_gnt", lsu_gnt, win_lsu);
        last_lsu = win_lsu;
        for (int c = 1; c <= busy_cycles; c++) begin
            @(negedge clk);
            ifu_req   = 1'($urandom_range(0, 1));
            lsu_req   = 1'($urandom_range(0, 1));
            ifu_addr  = $urandom;
            lsu_addr  = $urandom;
            lsu_wdata = $urandom;
            lsu_wmask = 8'($urandom);
            lsu_wen   = 1'($urandom_range(0, 1));
            mem_ready = ok && (c == lat);
            mem_rdata = (c == lat) ? rd : $urandom;
            #1;
            chk1("busy_mem_valid", mem_valid, 1'b1);
            chk1("busy_ifu_gnt", ifu_gnt, 1'b0);
            chk1("busy_lsu_gnt", lsu_gnt, 1'b0);
            chk32("busy_mem_raddr", mem_raddr, ea);
            chk32("busy_mem_waddr", mem_waddr, ea);
            chk1("busy_mem_ren", mem_ren, win_lsu ? !lw : 1'b1);
            chk1("busy_mem_wen", mem_wen, win_lsu ? lw : 1'b0);
            chk32("busy_mem_wmask", {24'h0, mem_wmask}, win_lsu ? {24'h0, wm} : 32'h0);
            if (win_lsu) begin
                chk32("busy_mem_wdata", mem_wdata, wd);
            end
            chk1("busy_ifu_resp", ifu_resp, 1'b0);
            chk1("busy_lsu_resp", lsu_resp, 1'b0);
        end
        @(negedge clk);
        ifu_req   = 1'b0;
        lsu_req   = 1'b0;
        mem_ready = 1'b0;
        if (win_lsu) begin
            exp_lsu_rdata = (ok && !lw) ? rd : 32'h0;
            exp_lsu_err   = !ok;
        end else begin
            exp_ifu_rdata = ok ? rd : 32'h0;
            exp_ifu_err   = !ok;
        end
        #1;
        chk1("resp_mem_valid", mem_valid, 1'b0);
        chk1("ifu_resp", ifu_resp, !win_lsu);
        chk1("lsu_resp", lsu_resp, win_lsu);
        chk32("ifu_rdata", ifu_rdata, exp_ifu_rdata);
        chk32("lsu_rdata", lsu_rdata, exp_lsu_rdata);
        chk1("ifu_err", ifu_err, exp_ifu_err);
        chk1("lsu_err", lsu_err, exp_lsu_err);
    endtask

    initial begin
        rst       = 1'b0;
        ifu_req   = 1'b0;
        ifu_addr  = 32'h0;
        lsu_req   = 1'b0;
        lsu_wen   = 1'b0;
        lsu_addr  = 32'h0;
        lsu_wdata = 32'h0;
        lsu_wmask = 8'h0;
        mem_rdata = 32'h0;
        mem_ready = 1'b0;
        model_reset();

        @(negedge clk);
        #1;
        reset_check();
        @(negedge clk);
        rst = 1'b1;

        // Four ties in a row alternate IFU, LSU, IFU, LSU.
        for (int i = 0; i < 4; i++) begin
            txn(1'b1, 1'b1, 1'b0, 32'h8000_0000 + 32'(i * 4), 32'h8000_1000 + 32'(i * 4),
                32'h0, 8'h0, 1, 32'h1111_0000 + 32'(i));
        end

        txn(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 8'h0, 1, 32'h0000_0413);
        txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 4, 32'hCAFE_F00D);
        txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_0020, 32'h0, 8'h0, 99, 32'h0);
        txn(1'b1, 1'b0, 1'b0, 32'h8000_0040, 32'h0, 32'h0, 8'h0, 2, 32'hA5A5_5A5A);
        txn(1'b1, 1'b0, 1'b0, 32'h8000_0044, 32'h0, 32'h0, 8'h0, TMO, 32'h1234_5678);
        idle(2);

        // Reset asserted during the second busy cycle aborts the transaction silently.
        @(negedge clk);
        ifu_req  = 1'b1;
        ifu_addr = 32'h8000_0100;
        #1;
        chk1("pre_rst_gnt", ifu_gnt, 1'b1);
        @(negedge clk);
        ifu_req = 1'b0;
        #1;
        chk1("pre_rst_valid1", mem_valid, 1'b1);
        @(negedge clk);
        #1;
        chk1("pre_rst_valid2", mem_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        reset_check();
        @(negedge clk);
        rst = 1'b1;
        txn(1'b1, 1'b0, 1'b0, 32'h8000_0200, 32'h0, 32'h0, 8'h0, 1, 32'h0BAD_F00D);

        for (int i = 0; i < 40; i++) begin
            int          sel;
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] wd;
            logic [31:0] rd;
            sel = $urandom_range(1, 3);
            a   = $urandom;
            b   = $urandom;
            wd  = $urandom;
            rd  = $urandom;
            txn(sel[0], sel[1], 1'($urandom_range(0, 1)), a, b, wd, 8'($urandom),
                $urandom_range(1, TMO + 2), rd);
            idle($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
